decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode/issue stage of the 16-bit CPU, directly upstream of the register file and EX.
//  Accepts a fetched instruction via valid/ready, decodes it and drives the register-file read addresses.
//  Latches operands, immediate and control into the ID/EX pipeline register.
//  Tracks in-flight loads in a 16-bit scoreboard and stalls on load-use hazards.
// PARAMETERS
//  XLEN      16   datapath / instruction width
//  NREGS     16   architectural registers (r0 hard-wired zero); address width 4
// PORTS
//  clk           in   1     clock, all state on posedge
//  rst           in   1     synchronous, active-high reset
//  if_valid      in   1     fetch holds a valid instruction
//  if_ready      out  1     stage accepts instruction this cycle
//  if_instr      in   16    [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4
//  if_pc         in   16    PC of if_instr
//  rf_rs1        out  4     regfile read address 1 (combinational from if_instr)
//  rf_rs2        out  4     regfile read address 2
//  rf_rs1_data   in   16    regfile read data 1 (regfile forwards same-cycle writes)
//  rf_rs2_data   in   16    regfile read data 2
//  wb_valid      in   1     writeback of a load result this cycle
//  wb_rd         in   4     destination of that writeback
//  flush         in   1     redirect from EX: kill ID/EX contents and the incoming instruction
//  ex_valid      out  1     ID/EX register holds a valid op
//  ex_ready      in   1     EX consumes ID/EX this cycle
//  ex_op         out  4     opcode
//  ex_rd         out  4     destination register
//  ex_a, ex_b    out  16    operand A (rs1 value), operand B (rs2 value, or rd value for ST)
//  ex_imm        out  16    sign-extended imm4, or zero-extended imm8 for LDI
//  ex_pc         out  16    PC of the op
//  ex_reg_write  out  1     op writes rd (forced 0 when rd==0)
//  ex_mem_read   out  1     op is LD
//  ex_mem_write  out  1     op is ST
//  ex_illegal    out  1     opcode 0xD/0xE
// BEHAVIOUR
//  - Opcodes: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR (R-type rd,rs1,rs2); 7 ADDI rd,rs1,simm4;
//    8 LDI rd,imm8 ([7:0]); 9 LD rd,[rs1+simm4]; A ST rd->[rs1+simm4] (rf_rs2=rd field);
//    B BEQ rs1==rd? pc+simm4 (rf_rs2=rd field); C JMP rs1; D,E illegal; F HALT.
//  - Reset: ex_valid=0, scoreboard=0, all ex_* data/control outputs=0; if_ready is 0 during reset.
//  - Latency: instruction accepted in cycle N appears on ex_* in cycle N+1.
//  - uses_rs1/uses_rs2 per opcode; reads of r0 never hazard.
//  - hazard = (uses_rs1 & pend[rs1]) | (uses_rs2 & pend[rs2]), with
//    pend = scoreboard & ~(wb_valid ? onehot(wb_rd) : 0) (regfile bypass covers same-cycle wb).
//  - if_ready = !rst & !hazard & (!ex_valid | ex_ready). Accept = if_valid & if_ready & !flush.
//  - ID/EX update: accept -> load new op, ex_valid=1; else if ex_ready -> ex_valid=0; else hold all.
//  - Stall inserts bubble: ex_valid=0 after EX drains; ex_* data held unchanged while ex_valid=0.
//  - Scoreboard: set bit rd on accept of LD with rd!=0; clear bit wb_rd on wb_valid.
//    Same-cycle set and clear of same bit -> set wins.
//  - flush: next cycle ex_valid=0, incoming instr dropped; scoreboard NOT cleared (loads in flight complete).
//  - HALT: once accepted, if_ready stays 0 until rst; ex_valid for HALT issued normally.
//  - Illegal op: issued with ex_illegal=1, ex_reg_write=0, no scoreboard update.
// STRUCTURE
//  - Package cpu_pkg: opcode localparams OP_ADD..OP_HALT, field-slice constants, XLEN.
//  - Sub-module decode_ctrl (combinational opcode -> uses_rs1/uses_rs2/reg_write/mem/imm-select).
//  - Top: scoreboard reg, halted flag, ID/EX register, handshake logic.
// TESTING
//  - Reset mid-stream: rst high 1 cycle with ex_valid=1 -> ex_valid=0, scoreboard=0 next cycle.
//  - ADDI r3,r1,-2 (0x731E), r1=5 -> next cycle ex_a=5, ex_imm=0xFFFE, ex_reg_write=1.
//  - LD r2,[r1+0] then ADD r4,r2,r2 -> 1+ stall cycles, if_ready=0 until wb_valid&wb_rd=2,
//    ADD accepted that cycle with ex_a = forwarded wb data.
//  - ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* held, if_ready=0; resume on ex_ready=1.
//  - flush with if_valid=1 -> instr not issued, ex_valid=0 next cycle, pending LD bit remains set.
//  - Opcode 0xD -> ex_illegal=1, ex_reg_write=0; HALT (0xF000) -> if_ready stuck 0 until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared constants for the 16-bit CPU front end
// Rev 1.0
// ============================================================================
package cpu_pkg;
  localparam int XLEN  = 16;
  localparam int NREGS = 16;
  localparam int RW    = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;
  localparam int IMM8_HI = 7;

  function automatic logic [XLEN-1:0] sext4(input logic [3:0] v);
    return {{(XLEN-4){v[3]}}, v};
  endfunction
endpackage
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// decode_ctrl : opcode -> operand usage and control flags (combinational)
// Rev 1.0
// ============================================================================
module decode_ctrl
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       rs2_from_rd,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       illegal,
  output logic       imm_zext8
);
  always_comb begin
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    rs2_from_rd = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    illegal     = 1'b0;
    imm_zext8   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        reg_write = 1'b1;
      end
      OP_ADDI: begin
        uses_rs1  = 1'b1;
        reg_write = 1'b1;
      end
      OP_LDI: begin
        reg_write = 1'b1;
        imm_zext8 = 1'b1;
      end
      OP_LD: begin
        uses_rs1  = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      // Stores and branches read the rd field as their second source.
      OP_ST: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        rs2_from_rd = 1'b1;
        mem_write   = 1'b1;
      end
      OP_BEQ: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        rs2_from_rd = 1'b1;
      end
      OP_JMP:  uses_rs1 = 1'b1;
      OP_HALT: ;
      default: illegal = 1'b1;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : decode/issue with load-use scoreboard and ID/EX register
// Rev 1.0
// ============================================================================
module decode_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [RW-1:0]   rf_rs1,
  output logic [RW-1:0]   rf_rs2,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_op,
  output logic [RW-1:0]   ex_rd,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
);
  localparam logic [NREGS-1:0] R0_MASK = NREGS'(1);

  logic [3:0]      op;
  logic [RW-1:0]   rd;
  logic            uses_rs1, uses_rs2, rs2_from_rd, reg_write;
  logic            mem_read, mem_write, illegal, imm_zext8;
  logic [NREGS-1:0] scoreboard, wb_clr, ld_set, pend;
  logic            halted, hazard, accept;
  logic [XLEN-1:0] imm;

  assign op = if_instr[OP_HI:OP_LO];
  assign rd = if_instr[RD_HI:RD_LO];

  decode_ctrl u_ctrl (
    .op          (op),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .rs2_from_rd (rs2_from_rd),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .illegal     (illegal),
    .imm_zext8   (imm_zext8)
  );

  assign rf_rs1 = if_instr[RS1_HI:RS1_LO];
  assign rf_rs2 = rs2_from_rd ? rd : if_instr[RS2_HI:RS2_LO];
  assign imm    = imm_zext8 ? {{(XLEN-8){1'b0}}, if_instr[IMM8_HI:0]}
                            : sext4(if_instr[RS2_HI:RS2_LO]);

  always_comb begin
    wb_clr = '0;
    if (wb_valid) wb_clr[wb_rd] = 1'b1;
  end

  // A load completing this cycle is already bypassed by the regfile.
  assign pend     = scoreboard & ~wb_clr & ~R0_MASK;
  assign hazard   = (uses_rs1 & pend[rf_rs1]) | (uses_rs2 & pend[rf_rs2]);
  assign if_ready = !rst && !halted && !hazard && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready && !flush;

  always_comb begin
    ld_set = '0;
    if (accept && mem_read && (rd != '0)) ld_set[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scoreboard <= '0;
      halted     <= 1'b0;
    end else begin
      scoreboard <= (scoreboard & ~wb_clr) | ld_set;
      if (accept && (op == OP_HALT)) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_op        <= '0;
      ex_rd        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_op        <= op;
      ex_rd        <= rd;
      ex_a         <= rf_rs1_data;
      ex_b         <= rf_rs2_data;
      ex_imm       <= imm;
      ex_pc        <= if_pc;
      ex_reg_write <= reg_write && (rd != '0);
      ex_mem_read  <= mem_read;
      ex_mem_write <= mem_write;
      ex_illegal   <= illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_decode_stage : directed stimulus, behavioural model and per-cycle compare
// Rev 1.0
// ============================================================================
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, wb_valid, flush, ex_valid, ex_ready;
  logic [15:0] if_instr, if_pc, rf_rs1_data, rf_rs2_data, wb_data;
  logic [3:0]  rf_rs1, rf_rs2, wb_rd, ex_op, ex_rd;
  logic [15:0] ex_a, ex_b, ex_imm, ex_pc;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
  );

  // Register file environment with same-cycle writeback bypass.
  logic [15:0] regs [16];
  always_comb begin
    rf_rs1_data = (rf_rs1 == 4'd0) ? 16'h0 :
                  (wb_valid && wb_rd == rf_rs1) ? wb_data : regs[rf_rs1];
    rf_rs2_data = (rf_rs2 == 4'd0) ? 16'h0 :
                  (wb_valid && wb_rd == rf_rs2) ? wb_data : regs[rf_rs2];
  end

  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Opcode property tables: bit k describes opcode k.
  localparam logic [15:0] T_RS1 = 16'h1EFF;
  localparam logic [15:0] T_RS2 = 16'h0C7F;
  localparam logic [15:0] T_WR  = 16'h03FF;

  logic        started = 1'b0;
  logic        m_valid, m_rw, m_mr, m_mw, m_ill, m_halted, m_ready, m_hz;
  logic [3:0]  m_op, m_rd, m_rs1, m_rs2, cur_op;
  logic [15:0] m_a, m_b, m_imm, m_pc, m_pend, t1, t2;

  always_comb begin
    t1     = T_RS1;
    t2     = T_RS2;
    cur_op = if_instr[15:12];
    m_rs1  = if_instr[7:4];
    m_rs2  = (cur_op == 4'hA || cur_op == 4'hB) ? if_instr[11:8] : if_instr[3:0];
    m_hz   = (t1[cur_op] && m_rs1 != 4'd0 && m_pend[m_rs1] && !(wb_valid && wb_rd == m_rs1)) ||
             (t2[cur_op] && m_rs2 != 4'd0 && m_pend[m_rs2] && !(wb_valid && wb_rd == m_rs2));
    m_ready = !rst && !m_halted && !m_hz && (!m_valid || ex_ready);
  end

  function automatic logic [15:0] rv(input logic [15:0] stored, input logic [3:0] r,
                                     input logic wv, input logic [3:0] wr, input logic [15:0] wd);
    if (r == 4'd0) return 16'h0;
    if (wv && wr == r) return wd;
    return stored;
  endfunction

  always @(posedge clk) begin
    logic        acc;
    logic [15:0] np, tw;
    if (rst) begin
      started  <= 1'b1;
      m_valid  <= 1'b0; m_op <= 4'h0; m_rd <= 4'h0;
      m_a <= 16'h0; m_b <= 16'h0; m_imm <= 16'h0; m_pc <= 16'h0;
      m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_ill <= 1'b0;
      m_pend <= 16'h0; m_halted <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 16'h1000 + 16'(i);
      regs[0] <= 16'h0;
      regs[1] <= 16'h0005;
    end else begin
      acc = if_valid && m_ready && !flush;
      tw  = T_WR;
      if (flush) m_valid <= 1'b0;
      else if (acc) begin
        m_valid <= 1'b1;
        m_op    <= cur_op;
        m_rd    <= if_instr[11:8];
        m_a     <= rv(regs[m_rs1], m_rs1, wb_valid, wb_rd, wb_data);
        m_b     <= rv(regs[m_rs2], m_rs2, wb_valid, wb_rd, wb_data);
        m_imm   <= (cur_op == 4'h8) ? {8'h00, if_instr[7:0]} : {{12{if_instr[3]}}, if_instr[3:0]};
        m_pc    <= if_pc;
        m_rw    <= tw[cur_op] && (if_instr[11:8] != 4'd0);
        m_mr    <= (cur_op == 4'h9);
        m_mw    <= (cur_op == 4'hA);
        m_ill   <= (cur_op == 4'hD) || (cur_op == 4'hE);
      end else if (ex_ready) m_valid <= 1'b0;
      np = m_pend;
      if (wb_valid) np[wb_rd] = 1'b0;
      if (acc && cur_op == 4'h9 && if_instr[11:8] != 4'd0) np[if_instr[11:8]] = 1'b1;
      m_pend <= np;
      if (acc && cur_op == 4'hF) m_halted <= 1'b1;
      if (wb_valid && wb_rd != 4'd0) regs[wb_rd] <= wb_data;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("if_ready", {15'h0, if_ready}, {15'h0, m_ready});
      chk("rf_rs1", {12'h0, rf_rs1}, {12'h0, m_rs1});
      chk("rf_rs2", {12'h0, rf_rs2}, {12'h0, m_rs2});
      chk("ex_valid", {15'h0, ex_valid}, {15'h0, m_valid});
      chk("ex_op", {12'h0, ex_op}, {12'h0, m_op});
      chk("ex_rd", {12'h0, ex_rd}, {12'h0, m_rd});
      chk("ex_a", ex_a, m_a);
      chk("ex_b", ex_b, m_b);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_ctrl", {12'h0, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
                     {12'h0, m_rw, m_mr, m_mw, m_ill});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    step();
    if_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0; if_pc = 16'h0;
    wb_valid = 1'b0; wb_rd = 4'h0; wb_data = 16'h0; flush = 1'b0; ex_ready = 1'b1;
    step(); step();
    chk("lit_rst_ready", {15'h0, if_ready}, 16'h0);
    chk("lit_rst_valid", {15'h0, ex_valid}, 16'h0);
    rst = 1'b0;

    if_valid = 1'b1; if_instr = 16'h731E; if_pc = 16'h0010; #1;
    chk("lit_idle_ready", {15'h0, if_ready}, 16'h1);
    step(); if_valid = 1'b0;
    chk("lit_addi_valid", {15'h0, ex_valid}, 16'h1);
    chk("lit_addi_a", ex_a, 16'h0005);
    chk("lit_addi_imm", ex_imm, 16'hFFFE);
    chk("lit_addi_rw", {15'h0, ex_reg_write}, 16'h1);

    issue(16'h0412, 16'h0011);
    issue(16'h1523, 16'h0012);
    issue(16'h6631, 16'h0013);
    issue(16'h86AB, 16'h0014);
    chk("lit_ldi_imm", ex_imm, 16'h00AB);
    issue(16'hA311, 16'h0015);
    chk("lit_st_b", ex_b, 16'h1003);
    chk("lit_st_mw", {15'h0, ex_mem_write}, 16'h1);
    issue(16'hB21F, 16'h0016);
    issue(16'hC010, 16'h0017);
    issue(16'h0012, 16'h0018);
    chk("lit_r0_rw", {15'h0, ex_reg_write}, 16'h0);
    issue(16'hD123, 16'h0019);
    chk("lit_ill", {15'h0, ex_illegal}, 16'h1);
    chk("lit_ill_rw", {15'h0, ex_reg_write}, 16'h0);

    // Load-use stall
    issue(16'h9210, 16'h0020);
    if_valid = 1'b1; if_instr = 16'h0422; if_pc = 16'h0021; #1;
    chk("lit_lu_stall", {15'h0, if_ready}, 16'h0);
    step();
    chk("lit_lu_bubble", {15'h0, ex_valid}, 16'h0);
    step();
    wb_valid = 1'b1; wb_rd = 4'd2; wb_data = 16'hBEEF; #1;
    chk("lit_lu_release", {15'h0, if_ready}, 16'h1);
    step();
    if_valid = 1'b0; wb_valid = 1'b0;
    chk("lit_lu_fwd_a", ex_a, 16'hBEEF);

    // EX backpressure
    issue(16'h0513, 16'h0040);
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = 16'h1513; if_pc = 16'h0041;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_bp_pc", ex_pc, 16'h0040);
      chk("lit_bp_ready", {15'h0, if_ready}, 16'h0);
    end
    ex_ready = 1'b1; #1;
    chk("lit_bp_resume", {15'h0, if_ready}, 16'h1);
    step(); if_valid = 1'b0;
    chk("lit_bp_next", ex_pc, 16'h0041);

    // Flush keeps the pending load
    issue(16'h9510, 16'h0050);
    flush = 1'b1;
    issue(16'h0711, 16'h0051);
    flush = 1'b0;
    chk("lit_flush_valid", {15'h0, ex_valid}, 16'h0);
    if_valid = 1'b1; if_instr = 16'h0851; if_pc = 16'h0052; #1;
    chk("lit_flush_pend", {15'h0, if_ready}, 16'h0);
    step();
    wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 16'h5555;
    step();
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("lit_flush_fwd", ex_a, 16'h5555);

    // Load to r0 never hazards
    issue(16'h9010, 16'h0058);
    if_valid = 1'b1; if_instr = 16'h0900; if_pc = 16'h0059; #1;
    chk("lit_r0_nohz", {15'h0, if_ready}, 16'h1);
    step(); if_valid = 1'b0;
    step();

    // Reset mid-stream
    ex_ready = 1'b0;
    issue(16'h9610, 16'h0060);
    chk("lit_mid_valid", {15'h0, ex_valid}, 16'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; ex_ready = 1'b1;
    chk("lit_mid_rst", {15'h0, ex_valid}, 16'h0);
    if_valid = 1'b1; if_instr = 16'h0766; if_pc = 16'h0061; #1;
    chk("lit_mid_sb", {15'h0, if_ready}, 16'h1);
    step(); if_valid = 1'b0;

    // HALT
    issue(16'hF000, 16'h0070);
    chk("lit_halt_op", {12'h0, ex_op}, 16'h000F);
    chk("lit_halt_pc", ex_pc, 16'h0070);
    if_valid = 1'b1; if_instr = 16'h0411; if_pc = 16'h0071;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_halt_ready", {15'h0, if_ready}, 16'h0);
    end
    if_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("lit_halt_clear", {15'h0, if_ready}, 16'h1);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
